// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: memToReg selector codes,
// default parameters and the sequencer state encoding.
package wb_pkg;

    localparam logic [3:0] SEL_A    = 4'b0000;
    localparam logic [3:0] SEL_B    = 4'b0001;
    localparam logic [3:0] SEL_C    = 4'b0010;
    localparam logic [3:0] SEL_D    = 4'b0011;
    localparam logic [3:0] SEL_E    = 4'b0100;
    localparam logic [3:0] SEL_F    = 4'b0101;
    localparam logic [3:0] SEL_G    = 4'b0110;
    localparam logic [3:0] SEL_H    = 4'b0111;
    localparam logic [3:0] SEL_227  = 4'b1000;
    localparam logic [3:0] SEL_ZERO = 4'b1001;
    localparam logic [3:0] SEL_ONE  = 4'b1010;
    localparam logic [3:0] SEL_MAX  = 4'b1010;

    localparam int SP_REG_DEFAULT  = 29;
    localparam int MEM_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_WRITE    = 3'd3,
        ST_REJECT   = 3'd4
    } wb_state_t;

    function automatic logic sel_is_illegal(input logic [3:0] sel);
        return sel > SEL_MAX;
    endfunction

endpackage

// File: rtl/wb_lat_counter.sv
// Loadable down-counter with a last-count flag, used to time memory wait states.
// The count saturates at zero so a stray decrement never wraps.
module wb_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/wb_ctrl.sv
// Write-back sequencer: drives memToReg select and register-bank write port,
// inserts load wait states and performs the stack-pointer write after reset.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int SP_REG  = SP_REG_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic       wb_mem,
    output logic [3:0] mem_to_reg,
    output logic       reg_write,
    output logic [4:0] reg_dst,
    output logic       mem_read,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       wb_illegal,
    output wb_state_t  dbg_state
);

    // Handshake: a request is taken only when wb_req=1 in a cycle where
    // wb_busy=0; in every other cycle wb_req is ignored with no side effects.

    wb_state_t  r_state;
    logic [3:0] r_src;
    logic [4:0] r_dst;
    logic       r_mem;
    logic [3:0] r_mem_to_reg;
    logic       r_reg_write;
    logic [4:0] r_reg_dst;
    logic       r_mem_read;
    logic       r_done;
    logic       r_illegal;

    logic       w_accept;
    logic       w_src_illegal;
    logic       w_load;
    logic       w_dec;
    logic       w_last;

    assign w_accept      = (r_state == ST_IDLE) && wb_req;
    assign w_src_illegal = sel_is_illegal(wb_src);
    assign w_load        = w_accept && !w_src_illegal && wb_mem;
    assign w_dec         = (r_state == ST_MEM_WAIT) && r_mem;

    wb_lat_counter #(
        .W(3)
    ) u_lat (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (3'(MEM_LAT)),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_src        <= '0;
            r_dst        <= '0;
            r_mem        <= 1'b0;
            r_mem_to_reg <= '0;
            r_reg_write  <= 1'b0;
            r_reg_dst    <= '0;
            r_mem_read   <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                // The SP write is presented in the first cycle out of reset;
                // once it has been shown the sequencer drops to IDLE.
                ST_INIT: begin
                    if (!r_reg_write) begin
                        r_reg_write  <= 1'b1;
                        r_mem_to_reg <= SEL_227;
                        r_reg_dst    <= 5'(SP_REG);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src <= wb_src;
                        r_dst <= wb_dst;
                        r_mem <= wb_mem;
                        if (w_src_illegal) begin
                            r_state   <= ST_REJECT;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                        end else if (wb_mem) begin
                            r_state    <= ST_MEM_WAIT;
                            r_mem_read <= 1'b1;
                        end else begin
                            r_state      <= ST_WRITE;
                            r_mem_to_reg <= wb_src;
                            r_reg_dst    <= wb_dst;
                            r_reg_write  <= (wb_dst != 5'd0);
                            r_done       <= 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_last) begin
                        r_state      <= ST_WRITE;
                        r_mem_to_reg <= r_src;
                        r_reg_dst    <= r_dst;
                        r_reg_write  <= (r_dst != 5'd0);
                        r_done       <= 1'b1;
                    end
                end
                ST_WRITE:  r_state <= ST_IDLE;
                ST_REJECT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_to_reg = r_mem_to_reg;
    assign reg_write  = r_reg_write;
    assign reg_dst    = r_reg_dst;
    assign mem_read   = r_mem_read;
    assign wb_done    = r_done;
    assign wb_illegal = r_illegal;
    assign wb_busy    = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: every output event (write, strobe, done) is
// predicted with its cycle number and checked by an independent monitor.
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int MEM_LAT = 2;
    localparam int SP_REG  = 29;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wb_req = 1'b0;
    logic [3:0] wb_src = '0;
    logic [4:0] wb_dst = '0;
    logic       wb_mem = 1'b0;
    logic [3:0] mem_to_reg;
    logic       reg_write;
    logic [4:0] reg_dst;
    logic       mem_read;
    logic       wb_busy;
    logic       wb_done;
    logic       wb_illegal;
    wb_state_t  dbg_state;

    wb_ctrl #(
        .MEM_LAT (MEM_LAT),
        .SP_REG  (SP_REG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_src     (wb_src),
        .wb_dst     (wb_dst),
        .wb_mem     (wb_mem),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_read   (mem_read),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done),
        .wb_illegal (wb_illegal),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: event = {mem_read, reg_write, wb_done, wb_illegal, sel, dst}
    logic [12:0] exp_q[$];
    int          cyc_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        rst_phase = 1'b1;
    int          bs = -1;
    int          be = -1;
    logic [3:0]  last_sel = '0;
    logic [4:0]  last_dst = '0;

    function automatic logic [12:0] ev(input logic mr, input logic rw, input logic dn,
                                       input logic il, input logic [3:0] sel,
                                       input logic [4:0] dst);
        return {mr, rw, dn, il, sel, dst};
    endfunction

    // monitor
    logic [12:0] m_obs;
    logic [12:0] m_exp;
    int          m_cyc;
    logic        m_busy;
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
            checks++;
            errors++;
            m_exp = exp_q.pop_front();
            m_cyc = cyc_q.pop_front();
            $display("FAIL missing_event cyc=%0d got=none exp=%h@%0d", cyc, m_exp, m_cyc);
        end
        m_obs = {mem_read, reg_write, wb_done, wb_illegal, mem_to_reg, reg_dst};
        if (mem_read === 1'b1 || reg_write === 1'b1 || wb_done === 1'b1 || wb_illegal === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got=%h exp=none", cyc, m_obs);
            end else begin
                m_exp = exp_q.pop_front();
                m_cyc = cyc_q.pop_front();
                if (m_obs !== m_exp || m_cyc != cyc) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h exp=%h@%0d", cyc, m_obs, m_exp, m_cyc);
                end
            end
        end
        m_busy = rst_phase || (cyc >= bs && cyc <= be);
        checks++;
        if (wb_busy !== m_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, wb_busy, m_busy);
        end
    end

    // driver tasks: all called and returning at negedge+1
    task automatic do_reset();
        int n;
        reset = 1'b1;
        wb_req = 1'b0;
        rst_phase = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({mem_to_reg, reg_dst, reg_write, mem_read, wb_done, wb_illegal, wb_busy} !== 14'b1) begin
            errors++;
            $display("FAIL reset_values got sel=%h dst=%0d rw=%b mr=%b dn=%b il=%b busy=%b exp sel=0 dst=0 busy=1",
                     mem_to_reg, reg_dst, reg_write, mem_read, wb_done, wb_illegal, wb_busy);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n = cyc;
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, SEL_227, 5'(SP_REG)));
        cyc_q.push_back(n);
        last_sel = SEL_227;
        last_dst = 5'(SP_REG);
        bs = n;
        be = n;
        rst_phase = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] src, input logic [4:0] dst, input logic mem);
        int n;
        int guard;
        guard = 0;
        while (wb_busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy=%b exp busy=0", wb_busy);
            return;
        end
        wb_req = 1'b1;
        wb_src = src;
        wb_dst = dst;
        wb_mem = mem;
        @(posedge clk);
        #1;
        n = cyc;
        wb_req = 1'b0;
        wb_src = 4'($urandom_range(0, 15));
        wb_dst = 5'($urandom_range(0, 31));
        wb_mem = 1'($urandom_range(0, 1));
        if (src > 4'd10) begin
            exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, last_sel, last_dst));
            cyc_q.push_back(n);
            bs = n;
            be = n;
        end else if (mem) begin
            exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, last_sel, last_dst));
            cyc_q.push_back(n);
            exp_q.push_back(ev(1'b0, dst != 5'd0, 1'b1, 1'b0, src, dst));
            cyc_q.push_back(n + MEM_LAT);
            last_sel = src;
            last_dst = dst;
            bs = n;
            be = n + MEM_LAT;
        end else begin
            exp_q.push_back(ev(1'b0, dst != 5'd0, 1'b1, 1'b0, src, dst));
            cyc_q.push_back(n);
            last_sel = src;
            last_dst = dst;
            bs = n;
            be = n;
        end
        @(negedge clk);
        #1;
    endtask

    // a request raised while the sequencer is busy; nothing may come of it
    task automatic poke();
        wb_req = 1'b1;
        wb_src = 4'($urandom_range(0, 15));
        wb_dst = 5'($urandom_range(1, 31));
        wb_mem = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        wb_req = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        issue(SEL_D, 5'd8, 1'b0);
        issue(SEL_B, 5'd9, 1'b1);
        issue(4'b1100, 5'd5, 1'b1);
        issue(SEL_ONE, 5'd0, 1'b0);
        issue(SEL_F, 5'd12, 1'b1);
        poke();
        issue(SEL_C, 5'd3, 1'b0);
        poke();
        issue(4'b1111, 5'd4, 1'b0);
        poke();
        issue(SEL_G, 5'd7, 1'b1);
        do_reset();
        issue(SEL_ZERO, 5'd31, 1'b0);
        for (int i = 0; i < 80; i++) begin
            issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) poke();
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Write-back sequencer for the multicycle datapath. It drives the 4-bit memToReg selector and the register-file write enable/destination, and it inserts the memory-latency wait states for loads. After every reset it performs the stack-pointer initialisation write, using the constant-227 mux leg into register 29. It sits between the main control FSM, which issues one write-back request per instruction, and the memToReg mux / register bank.

Parameters:
MEM_LAT, 2, cycles from memory read strobe to valid data at mux input; legal range 1..7
SP_REG, 29, register index written with 227 after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
wb_req  in  1  one-cycle request from main control; sampled only in IDLE
wb_src  in  4  requested memToReg code: 0000-0111 inputA-H, 1000 const 227, 1001 const 0, 1010 const 1
wb_dst  in  5  destination register index
wb_mem  in  1  source needs a memory read first (load)
mem_to_reg  out  4  selector to memToReg mux
reg_write  out  1  register-bank write enable
reg_dst  out  5  register-bank write address
mem_read  out  1  memory read strobe
wb_busy  out  1  high in every state except IDLE
wb_done  out  1  one-cycle pulse when a request completes (written, discarded or rejected)
wb_illegal  out  1  one-cycle pulse with wb_done when wb_src > 1010

Behaviour:
- Reset (reset=1 at an edge): state INIT. mem_to_reg=0000, reg_write=0, reg_dst=0, mem_read=0, wb_done=0, wb_illegal=0, wb_busy=1. The latency counter and latched fields clear.
- Reset asserted in any state aborts that state immediately. No write, strobe or done pulse is produced in the cycle after the reset edge.
- INIT: entered for exactly one cycle after reset deasserts.
  - Outputs: reg_write=1, mem_to_reg=1000, reg_dst=SP_REG, wb_busy=1, wb_done=0.
  - Next state: IDLE.
- IDLE: wb_busy=0, reg_write=0, mem_read=0.
  - mem_to_reg and reg_dst hold their last driven values so the mux select stays stable.
  - On wb_req=1, latch wb_src, wb_dst and wb_mem, then branch:
    - wb_src > 1010: go to REJECT.
    - wb_mem=1: go to MEM_WAIT and load the counter with MEM_LAT.
    - otherwise: go to WRITE.
- MEM_WAIT: wb_busy=1.
  - mem_read=1 only in the first MEM_WAIT cycle.
  - Counter decrements each cycle; at count 1 go to WRITE.
  - MEM_WAIT therefore lasts exactly MEM_LAT cycles.
- WRITE: exactly one cycle.
  - mem_to_reg = latched src, reg_dst = latched dst, wb_done=1.
  - reg_write=1 unless latched dst=0; $zero writes are suppressed but wb_done still pulses.
  - Next state: IDLE.
- REJECT: one cycle, wb_done=1, wb_illegal=1, reg_write=0, mem_to_reg unchanged. Next state: IDLE.
- Latency, measured from a request accepted at edge t:
  - Non-memory request: write at cycle t+1.
  - Memory request: mem_read at t+1, write at t+1+MEM_LAT.
- Back-to-back operation: wb_req arriving in the WRITE or REJECT cycle is ignored. The earliest next acceptance is the IDLE cycle that follows, giving one request per 2 cycles minimum.
- wb_req while wb_busy=1 is ignored with no side effects. The requester must wait for wb_busy=0.
- wb_mem combined with an illegal src: REJECT takes priority and mem_read is never asserted.
- Widths: reg_dst and mem_to_reg are registered outputs. The counter is 3 bits and saturates at 0.

Decomposition:
- Shared package wb_pkg holds:
  - selector constants SEL_A..SEL_H (0000-0111), SEL_227=1000, SEL_ZERO=1001, SEL_ONE=1010, SEL_MAX=1010
  - SP_REG default 29
  - state encoding INIT/IDLE/MEM_WAIT/WRITE/REJECT, 3 bits
- The main control FSM imports the same selector constants.
- Sub-module wb_lat_counter (load, decrement, last-count flag) is natural and reusable for other memory wait sequencing.

Test Plan:
- Reset for 2 cycles then release -> next cycle reg_write=1, mem_to_reg=1000, reg_dst=29, wb_busy=1; following cycle IDLE, wb_busy=0.
- IDLE, wb_req with src=0011, dst=8, mem=0 at edge t -> cycle t+1: reg_write=1, mem_to_reg=0011, reg_dst=8, wb_done=1; mem_read never asserted.
- wb_req with src=0001, dst=9, mem=1, MEM_LAT=2 at t -> mem_read=1 at t+1 only; reg_write=1 with mem_to_reg=0001, reg_dst=9 at t+3; wb_done at t+3.
- wb_req with src=1100, mem=1 -> next cycle wb_done=1, wb_illegal=1, reg_write=0, mem_read=0; mem_to_reg keeps its prior value.
- wb_req with src=1010, dst=0 -> wb_done=1, reg_write=0; then a second wb_req during MEM_WAIT of a load is ignored, and only one write occurs.
- Reset asserted in the first MEM_WAIT cycle -> no reg_write or wb_done follows; the INIT SP write occurs once reset deasserts.
